pwm_breathe_multi: RTL and testbench

- Multi-channel successor to the single-LED breathing PWM. One shared period/step timebase drives CH PWM outputs.
- Each channel's duty follows a triangle "breathe" ramp with a per-channel phase offset.
- Run-time selectable modes: off, fixed level, breathe, blink.
- Configuration arrives over a valid/ready handshake and is applied only at a PWM period boundary, so outputs never glitch.
- Sits between the top-level LED pins and the control/register logic.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_chan.sv | 53 +++++
 rtl/pwm_breathe_multi.sv | 135 +++++++++++++
 tb/tb_pwm_breathe_multi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel breathing PWM: mode encodings and
// the level helpers used by the timebase and the per-channel slices.
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_FIXED   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // Triangle ramp: 1, 2, .., steps, steps, .., 1 over 2*steps positions.
  function automatic int unsigned tri_level(input int unsigned s, input int unsigned steps);
    return (s < steps) ? s + 1 : 2 * steps - s;
  endfunction

  function automatic int unsigned clamp_level(input int unsigned lvl, input int unsigned steps);
    return (lvl > steps) ? steps : lvl;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel slice: turns the shared cycle count, this channel's ramp
// step, the active mode and the fixed level into one registered lit bit.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 10,
  parameter int unsigned STEPS  = 5,
  parameter int unsigned CW     = 4,
  parameter int unsigned SW     = 4,
  parameter int unsigned LW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cyc_i,
  input  logic [SW-1:0] sk_i,
  input  mode_e         mode_i,
  input  logic [LW-1:0] level_i,
  output logic          lit_o
);

  localparam int unsigned STEP_SZ = PERIOD / STEPS;

  logic lit_q;
  logic lit_d;

  // Top level is forced to the full period so truncation in STEP_SZ never
  // leaves a dark tail at maximum brightness.
  function automatic int unsigned on_cycles(input int unsigned lvl);
    return (lvl >= STEPS) ? PERIOD : lvl * STEP_SZ;
  endfunction

  always_comb begin
    lit_d = 1'b0;
    case (mode_i)
      MODE_OFF:     lit_d = 1'b0;
      MODE_FIXED:   lit_d = 32'(cyc_i) < on_cycles(32'(level_i));
      MODE_BREATHE: lit_d = 32'(cyc_i) < on_cycles(tri_level(32'(sk_i), STEPS));
      MODE_BLINK:   lit_d = ~sk_i[0];
      default:      lit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lit_q <= 1'b0;
    end else begin
      lit_q <= lit_d;
    end
  end

  assign lit_o = lit_q;

endmodule

// File: rtl/pwm_breathe_multi.sv
// Multi-channel breathing PWM: shared period/rep/step timebase, config
// handshake applied only at period boundaries, and output polarity.
module pwm_breathe_multi
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD     = 500000,
  parameter int unsigned REPS       = 200,
  parameter int unsigned STEPS      = 5,
  parameter int unsigned CH         = 4,
  parameter int unsigned PHASE      = 1,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned RESET_MODE = 2,
  localparam int unsigned LW = $clog2(STEPS + 1),
  localparam int unsigned SW = $clog2(2 * STEPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [1:0]    mode_i,
  input  logic [LW-1:0] level_i,
  output logic [CH-1:0] led_o,
  output logic          period_end_o,
  output logic [SW-1:0] step_o
);

  localparam int unsigned CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned RW    = (REPS > 1) ? $clog2(REPS) : 1;
  localparam int unsigned NSTEP = 2 * STEPS;
  localparam mode_e       RST_MODE = mode_e'(2'(RESET_MODE));

  logic [CW-1:0] cyc_q, cyc_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [SW-1:0] step_q, step_d;
  logic          pe_q;
  logic          pend_q, pend_d;
  mode_e         mode_q, mode_d;
  mode_e         pmode_q, pmode_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] plevel_q, plevel_d;
  logic          period_end;
  logic          rep_last;
  logic          xfer;
  logic [CH-1:0] lit;

  always_comb begin
    period_end = (cyc_q == CW'(PERIOD - 1));
    rep_last   = (rep_q == RW'(REPS - 1));
    xfer       = cfg_valid_i && !pend_q;

    cyc_d  = period_end ? '0 : cyc_q + 1'b1;
    rep_d  = rep_q;
    step_d = step_q;
    if (period_end) begin
      rep_d = rep_last ? '0 : rep_q + 1'b1;
      if (rep_last) begin
        step_d = (step_q == SW'(NSTEP - 1)) ? '0 : step_q + 1'b1;
      end
    end

    mode_d   = mode_q;
    level_d  = level_q;
    pend_d   = pend_q;
    pmode_d  = pmode_q;
    plevel_d = plevel_q;
    // Applying a pending config takes priority; a transfer landing on the
    // boundary itself only fills the pending slot and waits a full period.
    if (period_end && pend_q) begin
      mode_d  = pmode_q;
      level_d = plevel_q;
      pend_d  = 1'b0;
    end else if (xfer) begin
      pend_d   = 1'b1;
      pmode_d  = mode_e'(mode_i);
      plevel_d = LW'(clamp_level(32'(level_i), STEPS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      rep_q    <= '0;
      step_q   <= '0;
      pe_q     <= 1'b0;
      pend_q   <= 1'b0;
      mode_q   <= RST_MODE;
      level_q  <= '0;
      pmode_q  <= MODE_OFF;
      plevel_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      rep_q    <= rep_d;
      step_q   <= step_d;
      pe_q     <= period_end;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      level_q  <= level_d;
      pmode_q  <= pmode_d;
      plevel_q <= plevel_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam int unsigned OFS = (k * PHASE) % NSTEP;

    logic [SW:0]   sum;
    logic [SW-1:0] sk;

    // Offset is pre-reduced, so one conditional subtract replaces the modulo.
    assign sum = {1'b0, step_q} + (SW + 1)'(OFS);
    assign sk  = (sum >= (SW + 1)'(NSTEP)) ? SW'(sum - (SW + 1)'(NSTEP)) : sum[SW-1:0];

    pwm_chan #(
      .PERIOD (PERIOD),
      .STEPS  (STEPS),
      .CW     (CW),
      .SW     (SW),
      .LW     (LW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .cyc_i   (cyc_q),
      .sk_i    (sk),
      .mode_i  (mode_q),
      .level_i (level_q),
      .lit_o   (lit[k])
    );
  end

  assign led_o        = ACTIVE_LOW ? ~lit : lit;
  assign cfg_ready_o  = ~pend_q;
  assign period_end_o = pe_q;
  assign step_o       = step_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Randomized bench for pwm_breathe_multi: a time-indexed reference model
// predicts every output each cycle from the absolute cycle count since reset.
module tb_pwm_breathe_multi;

  localparam int unsigned PERIOD     = 10;
  localparam int unsigned REPS       = 2;
  localparam int unsigned STEPS      = 5;
  localparam int unsigned CH         = 2;
  localparam int unsigned PHASE      = 1;
  localparam bit          ACTIVE_LOW = 1'b1;
  localparam int unsigned RESET_MODE = 2;
  localparam int unsigned LW         = $clog2(STEPS + 1);
  localparam int unsigned SW         = $clog2(2 * STEPS);
  localparam int unsigned NCYC       = 3200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [1:0]    mode_i;
  logic [LW-1:0] level_i;
  logic [CH-1:0] led_o;
  logic          period_end_o;
  logic [SW-1:0] step_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state, valid for the cycle whose counter index is t.
  int unsigned t;
  int unsigned m_mode, m_level, m_pend, pm_mode, pm_level;
  int unsigned prev_mode, prev_level;

  always #5 clk = ~clk;

  pwm_breathe_multi #(
    .PERIOD     (PERIOD),
    .REPS       (REPS),
    .STEPS      (STEPS),
    .CH         (CH),
    .PHASE      (PHASE),
    .ACTIVE_LOW (ACTIVE_LOW),
    .RESET_MODE (RESET_MODE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .mode_i       (mode_i),
    .level_i      (level_i),
    .led_o        (led_o),
    .period_end_o (period_end_o),
    .step_o       (step_o)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // Whether channel k is lit in counter cycle u under the given mode/level.
  function automatic bit exp_lit(input int unsigned mode, input int unsigned level,
                                 input int unsigned u, input int unsigned k);
    int unsigned cyc, st, s, lvl, on;
    cyc = u % PERIOD;
    st  = (u / (PERIOD * REPS)) % (2 * STEPS);
    s   = (st + k * PHASE) % (2 * STEPS);
    case (mode)
      0: return 1'b0;
      1: lvl = level;
      2: lvl = (s < STEPS) ? s + 1 : 2 * STEPS - s;
      default: return (s % 2) == 0;
    endcase
    on = (lvl == STEPS) ? PERIOD : lvl * (PERIOD / STEPS);
    return cyc < on;
  endfunction

  function automatic logic [CH-1:0] exp_led(input int unsigned mode, input int unsigned level,
                                            input int unsigned u);
    logic [CH-1:0] v;
    for (int unsigned k = 0; k < CH; k++) begin
      v[k] = ACTIVE_LOW ? !exp_lit(mode, level, u, k) : exp_lit(mode, level, u, k);
    end
    return v;
  endfunction

  task automatic model_reset();
    t        = 0;
    m_mode   = RESET_MODE;
    m_level  = 0;
    m_pend   = 0;
    pm_mode  = 0;
    pm_level = 0;
  endtask

  initial begin
    logic [CH-1:0] exp_l;
    logic [CH-1:0] idle;
    bit            req;
    bit            arm;
    bit            acc;
    logic          rst_now;
    logic [1:0]    req_mode;
    logic [LW-1:0] req_level;

    idle        = ACTIVE_LOW ? '1 : '0;
    req         = 1'b0;
    arm         = 1'b0;
    req_mode    = '0;
    req_level   = '0;
    rst_n       = 1'b0;
    cfg_valid_i = 1'b0;
    mode_i      = '0;
    level_i     = '0;
    repeat (2) @(posedge clk);
    model_reset();
    prev_mode  = m_mode;
    prev_level = m_level;

    for (int unsigned n = 0; n < NCYC; n++) begin
      @(negedge clk);
      exp_l = (t == 0) ? idle : exp_led(prev_mode, prev_level, t - 1);
      check_val("led", 32'(led_o), 32'(exp_l));
      check_val("step", 32'(step_o), (t / (PERIOD * REPS)) % (2 * STEPS));
      check_val("period_end", 32'(period_end_o), 32'(t > 0 && (t % PERIOD) == 0));
      check_val("cfg_ready", 32'(cfg_ready_o), 32'(m_pend == 0));

      rst_now = 1'b1;
      if (n == 233) begin
        req = 1'b1; req_mode = 2'd1; req_level = 3'd3;
      end else if (n == 269) begin
        req = 1'b1; req_mode = 2'd1; req_level = 3'd7;
      end else if (n == 309) begin
        req = 1'b1; req_mode = 2'd3; req_level = 3'd0;
      end else if (n >= 560) begin
        if (!req && $urandom_range(0, 29) == 0) begin
          req       = 1'b1;
          req_mode  = 2'($urandom_range(0, 3));
          req_level = LW'($urandom_range(0, 7));
        end
        if (n % 700 == 0) arm = 1'b1;
        if (arm && m_pend != 0) begin
          rst_now = 1'b0;
          arm     = 1'b0;
        end
      end

      rst_n       = rst_now;
      cfg_valid_i = req;
      mode_i      = req_mode;
      level_i     = req_level;

      acc = rst_now && req && (m_pend == 0);
      if (!rst_now) begin
        model_reset();
      end else begin
        prev_mode  = m_mode;
        prev_level = m_level;
        if (m_pend != 0 && (t % PERIOD) == PERIOD - 1) begin
          m_mode  = pm_mode;
          m_level = pm_level;
          m_pend  = 0;
        end else if (acc) begin
          m_pend   = 1;
          pm_mode  = 32'(req_mode);
          pm_level = (32'(req_level) > STEPS) ? STEPS : 32'(req_level);
        end
        t++;
      end
      if (acc) req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
